// File: rtl/pwm_pkg.sv
// pwm_pkg
// Shared definitions for the PWM configuration slice: the register map of the
// write/read port, the bit positions inside the CTRL register and the state
// encoding of the configuration controller FSM.
// No ports (package).

package pwm_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 16;

    // Register map of the configuration port
    localparam logic [ADDR_W-1:0] ADDR_PERIOD   = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_PRESCALE = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_CTRL     = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_COMMIT   = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_SOFTRST  = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_STATUS   = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_COUNT    = 3'd6;

    // Bit positions inside the CTRL register
    localparam int CTRL_EN_BIT = 0;
    localparam int CTRL_UP_BIT = 1;

    // Configuration controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RSTP  = 2'd2
    } cfg_state_t;

endpackage

// File: rtl/pwm_wrap_detect.sv
// pwm_wrap_detect
// Watches the live counter value and flags the cycle in which the counter has
// just wrapped, so that a pending configuration change can be applied at a
// period boundary.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_count_val    : live counter value
//   i_upnotdown    : active count direction (1 = up)
//   o_boundary     : 1 while the counter has just wrapped

module pwm_wrap_detect
    import pwm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] i_count_val,
    input  logic              i_upnotdown,
    output logic              o_boundary
);

    logic [DATA_W-1:0] r_countValQ;
    logic              w_changed;

    // Keep last cycle's counter value so a change of value can be seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_countValQ <= '0;
        end else begin
            r_countValQ <= i_count_val;
        end
    end

    // Counting up, the wrap is the step onto 0. Counting down, the wrap is the
    // step away from 0 (back up to the period value), so the previous value is
    // the one compared against zero.
    assign w_changed  = (i_count_val != r_countValQ);
    assign o_boundary = w_changed &&
                        (i_upnotdown ? (i_count_val == '0) : (r_countValQ == '0));

endmodule

// File: rtl/pwm_cfg_ctrl.sv
// pwm_cfg_ctrl
// Configuration controller for the PWM counter. Register writes update shadow
// copies of period, prescale and control bits; a commit copies all shadows to
// the active outputs together, either at the next counter wrap or right away.
// A SOFTRST write produces a one-cycle counter clear. Reads are registered.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   i_wr_valid/o_wr_ready, i_wr_addr, i_wr_data : register write port
//   i_rd_addr/o_rd_data : read port, one cycle latency
//   i_count_val         : live counter value (for wrap detection and COUNT)
//   o_period, o_prescale, o_upnotdown, o_en : active counter configuration
//   o_count_reset       : one-cycle synchronous counter clear
//   o_commit_pending    : a commit is armed and waiting

module pwm_cfg_ctrl
    import pwm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic [DATA_W-1:0] i_count_val,
    output logic [DATA_W-1:0] o_period,
    output logic [7:0]        o_prescale,
    output logic              o_upnotdown,
    output logic              o_en,
    output logic              o_count_reset,
    output logic              o_commit_pending
);

    cfg_state_t        r_state;
    cfg_state_t        w_stateNext;
    logic              r_force;
    logic              w_forceNext;
    logic              r_rstpPending;
    logic              w_rstpPendingNext;
    logic              w_load;
    logic              w_boundary;
    logic              w_wrFire;
    logic              w_commitCond;

    logic [DATA_W-1:0] r_shadowPeriod;
    logic [7:0]        r_shadowPrescale;
    logic              r_shadowEn;
    logic              r_shadowUp;

    logic [DATA_W-1:0] r_period;
    logic [7:0]        r_prescale;
    logic              r_en;
    logic              r_upnotdown;

    logic [DATA_W-1:0] r_rdData;
    logic [DATA_W-1:0] w_rdMux;

    pwm_wrap_detect u_wrap_detect (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_count_val (i_count_val),
        .i_upnotdown (r_upnotdown),
        .o_boundary  (w_boundary)
    );

    assign w_wrFire = i_wr_valid && o_wr_ready;

    // A stopped counter or a zero period never produces a wrap, so an armed
    // commit would otherwise wait forever; commit straight away in those cases.
    assign w_commitCond = w_boundary || r_force || !r_en || (r_period == '0);

    // FSM state, force flag and the "commit still owed" flag carried through RSTP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_force       <= 1'b0;
            r_rstpPending <= 1'b0;
        end else begin
            r_state       <= w_stateNext;
            r_force       <= w_forceNext;
            r_rstpPending <= w_rstpPendingNext;
        end
    end

    // Next-state decode and FSM outputs. In ARMED a commit and a SOFTRST may
    // land on the same edge: the commit is taken and RSTP still follows.
    always_comb begin
        w_stateNext       = r_state;
        w_forceNext       = r_force;
        w_rstpPendingNext = r_rstpPending;
        w_load            = 1'b0;
        o_wr_ready        = 1'b1;
        o_count_reset     = 1'b0;
        o_commit_pending  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_wrFire && (i_wr_addr == ADDR_SOFTRST)) begin
                    w_stateNext       = ST_RSTP;
                    w_rstpPendingNext = 1'b0;
                end else if (w_wrFire && (i_wr_addr == ADDR_COMMIT)) begin
                    w_stateNext = ST_ARMED;
                    w_forceNext = i_wr_data[0];
                end
            end
            ST_ARMED: begin
                o_commit_pending = 1'b1;
                if (w_commitCond) begin
                    w_load      = 1'b1;
                    w_forceNext = 1'b0;
                    w_stateNext = ST_IDLE;
                end else if (w_wrFire && (i_wr_addr == ADDR_COMMIT) && i_wr_data[0]) begin
                    w_forceNext = 1'b1;
                end
                if (w_wrFire && (i_wr_addr == ADDR_SOFTRST)) begin
                    w_stateNext       = ST_RSTP;
                    w_rstpPendingNext = 1'b1;
                    w_forceNext       = 1'b0;
                end
            end
            ST_RSTP: begin
                o_wr_ready        = 1'b0;
                o_count_reset     = 1'b1;
                o_commit_pending  = r_rstpPending;
                w_load            = r_rstpPending;
                w_rstpPendingNext = 1'b0;
                w_stateNext       = ST_IDLE;
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Shadow register file; writes to read-only or reserved addresses fall
    // through without effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadowPeriod   <= '0;
            r_shadowPrescale <= '0;
            r_shadowEn       <= 1'b0;
            r_shadowUp       <= 1'b1;
        end else if (w_wrFire) begin
            case (i_wr_addr)
                ADDR_PERIOD:   r_shadowPeriod   <= i_wr_data;
                ADDR_PRESCALE: r_shadowPrescale <= i_wr_data[7:0];
                ADDR_CTRL: begin
                    r_shadowEn <= i_wr_data[CTRL_EN_BIT];
                    r_shadowUp <= i_wr_data[CTRL_UP_BIT];
                end
                default: ;
            endcase
        end
    end

    // Active configuration: every field is loaded on the same edge so the
    // counter never sees a half-updated setup.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period    <= '0;
            r_prescale  <= '0;
            r_en        <= 1'b0;
            r_upnotdown <= 1'b1;
        end else if (w_load) begin
            r_period    <= r_shadowPeriod;
            r_prescale  <= r_shadowPrescale;
            r_en        <= r_shadowEn;
            r_upnotdown <= r_shadowUp;
        end
    end

    // Read mux: shadows (not active values) for 0-2, zero for write-only and
    // reserved addresses.
    always_comb begin
        w_rdMux = '0;
        case (i_rd_addr)
            ADDR_PERIOD:   w_rdMux = r_shadowPeriod;
            ADDR_PRESCALE: w_rdMux = {8'd0, r_shadowPrescale};
            ADDR_CTRL:     w_rdMux = {14'd0, r_shadowUp, r_shadowEn};
            ADDR_STATUS:   w_rdMux = {15'd0, o_commit_pending};
            ADDR_COUNT:    w_rdMux = i_count_val;
            default:       w_rdMux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdData <= '0;
        end else begin
            r_rdData <= w_rdMux;
        end
    end

    assign o_rd_data   = r_rdData;
    assign o_period    = r_period;
    assign o_prescale  = r_prescale;
    assign o_en        = r_en;
    assign o_upnotdown = r_upnotdown;

endmodule

// File: tb/tb_pwm_cfg_ctrl.sv
// tb_pwm_cfg_ctrl
// Directed bench for pwm_cfg_ctrl. The counter is played by the bench, which
// drives count_val by hand. Inputs change and outputs are sampled 1 time unit
// after the rising edge.

module tb_pwm_cfg_ctrl;

    logic        clk;
    logic        rst_n;
    logic        i_wr_valid;
    logic        o_wr_ready;
    logic [2:0]  i_wr_addr;
    logic [15:0] i_wr_data;
    logic [2:0]  i_rd_addr;
    logic [15:0] o_rd_data;
    logic [15:0] i_count_val;
    logic [15:0] o_period;
    logic [7:0]  o_prescale;
    logic        o_upnotdown;
    logic        o_en;
    logic        o_count_reset;
    logic        o_commit_pending;

    int vectors;
    int miscompares;

    pwm_cfg_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_wr_valid       (i_wr_valid),
        .o_wr_ready       (o_wr_ready),
        .i_wr_addr        (i_wr_addr),
        .i_wr_data        (i_wr_data),
        .i_rd_addr        (i_rd_addr),
        .o_rd_data        (o_rd_data),
        .i_count_val      (i_count_val),
        .o_period         (o_period),
        .o_prescale       (o_prescale),
        .o_upnotdown      (o_upnotdown),
        .o_en             (o_en),
        .o_count_reset    (o_count_reset),
        .o_commit_pending (o_commit_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted register write; the write lands on the edge inside this task.
    task automatic applyStimulus(input logic [2:0] addr, input logic [15:0] data);
        i_wr_valid = 1'b1;
        i_wr_addr  = addr;
        i_wr_data  = data;
        tick();
        i_wr_valid = 1'b0;
        i_wr_addr  = 3'd7;
        i_wr_data  = 16'h0000;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        i_wr_valid  = 1'b0;
        i_wr_addr   = 3'd7;
        i_wr_data   = 16'h0000;
        i_rd_addr   = 3'd0;
        i_count_val = 16'd0;

        // Reset values
        #12;
        checkOutput("rst_period",   o_period,         16'd0);
        checkOutput("rst_prescale", {8'd0, o_prescale}, 16'd0);
        checkOutput("rst_en",       o_en,             16'd0);
        checkOutput("rst_up",       o_upnotdown,      16'd1);
        checkOutput("rst_wr_ready", o_wr_ready,       16'd1);
        checkOutput("rst_rd_data",  o_rd_data,        16'd0);
        checkOutput("rst_cnt_rst",  o_count_reset,    16'd0);
        checkOutput("rst_pending",  o_commit_pending, 16'd0);
        rst_n = 1'b1;
        tick();

        // Immediate commit of PERIOD=9, CTRL=3
        $display("[TB] immediate commit");
        applyStimulus(3'd0, 16'd9);
        applyStimulus(3'd2, 16'h0003);
        applyStimulus(3'd3, 16'h0001);
        checkOutput("imm_pending_armed", o_commit_pending, 16'd1);
        checkOutput("imm_period_before", o_period,         16'd0);
        checkOutput("imm_rd_shadow",     o_rd_data,        16'd9);
        tick();
        checkOutput("imm_period", o_period,         16'd9);
        checkOutput("imm_en",     o_en,             16'd1);
        checkOutput("imm_up",     o_upnotdown,      16'd1);
        checkOutput("imm_pending",o_commit_pending, 16'd0);

        // Boundary commit, counting up: PERIOD=4 waits for 9 -> 0
        $display("[TB] boundary commit up");
        i_count_val = 16'd5;
        tick();
        applyStimulus(3'd0, 16'd4);
        i_rd_addr = 3'd5;
        applyStimulus(3'd3, 16'h0000);
        checkOutput("up_pending_armed", o_commit_pending, 16'd1);
        checkOutput("up_period_hold1",  o_period,         16'd9);
        i_count_val = 16'd9;
        tick();
        checkOutput("up_rd_status",     o_rd_data,        16'd1);
        checkOutput("up_period_hold2",  o_period,         16'd9);
        checkOutput("up_pending_hold",  o_commit_pending, 16'd1);
        i_count_val = 16'd0;
        tick();
        checkOutput("up_period_wrap",   o_period,         16'd4);
        checkOutput("up_pending_clear", o_commit_pending, 16'd0);
        i_rd_addr = 3'd6;
        tick();
        checkOutput("rd_count", o_rd_data, 16'd0);

        // Switch to down mode (en=1, up=0) with an immediate commit
        $display("[TB] boundary commit down");
        applyStimulus(3'd2, 16'h0001);
        applyStimulus(3'd3, 16'h0001);
        tick();
        checkOutput("dn_up", o_upnotdown, 16'd0);
        i_count_val = 16'd2;
        tick();
        i_count_val = 16'd1;
        tick();
        applyStimulus(3'd1, 16'h0003);
        applyStimulus(3'd3, 16'h0000);
        checkOutput("dn_pending_armed", o_commit_pending,    16'd1);
        checkOutput("dn_presc_hold1",   {8'd0, o_prescale},  16'd0);
        i_count_val = 16'd0;
        tick();
        checkOutput("dn_presc_hold2",   {8'd0, o_prescale},  16'd0);
        i_count_val = 16'd4;
        tick();
        checkOutput("dn_presc_wrap",    {8'd0, o_prescale},  16'd3);
        checkOutput("dn_pending_clear", o_commit_pending,    16'd0);

        // SOFTRST while armed: one-cycle clear, shadows applied on exit
        $display("[TB] softrst while armed");
        applyStimulus(3'd0, 16'd7);
        applyStimulus(3'd3, 16'h0000);
        applyStimulus(3'd4, 16'h0000);
        checkOutput("srst_wr_ready",   o_wr_ready,       16'd0);
        checkOutput("srst_cnt_rst",    o_count_reset,    16'd1);
        checkOutput("srst_pending",    o_commit_pending, 16'd1);
        checkOutput("srst_period_old", o_period,         16'd4);
        tick();
        checkOutput("srst_cnt_rst_off", o_count_reset,    16'd0);
        checkOutput("srst_wr_ready_on", o_wr_ready,       16'd1);
        checkOutput("srst_period_new",  o_period,         16'd7);
        checkOutput("srst_pending_off", o_commit_pending, 16'd0);

        // Active en=0: a boundary commit goes through on the next edge
        $display("[TB] commit with counter disabled");
        applyStimulus(3'd2, 16'h0002);
        applyStimulus(3'd3, 16'h0001);
        tick();
        checkOutput("dis_en", o_en,        16'd0);
        checkOutput("dis_up", o_upnotdown, 16'd1);
        applyStimulus(3'd0, 16'd12);
        applyStimulus(3'd3, 16'h0000);
        checkOutput("dis_pending", o_commit_pending, 16'd1);
        tick();
        checkOutput("dis_period",     o_period,         16'd12);
        checkOutput("dis_pending_off",o_commit_pending, 16'd0);

        // Writes to read-only / reserved addresses are ignored; reads return 0
        applyStimulus(3'd5, 16'hFFFF);
        applyStimulus(3'd7, 16'hFFFF);
        i_rd_addr = 3'd0;
        tick();
        checkOutput("ro_wr_ignored", o_rd_data, 16'd12);
        i_rd_addr = 3'd7;
        tick();
        checkOutput("rd_reserved", o_rd_data, 16'd0);
        i_rd_addr = 3'd3;
        tick();
        checkOutput("rd_commit_wo", o_rd_data, 16'd0);

        // Asynchronous reset while armed clears everything
        $display("[TB] reset while armed");
        applyStimulus(3'd2, 16'h0003);
        applyStimulus(3'd3, 16'h0001);
        tick();
        checkOutput("pre_rst_en", o_en, 16'd1);
        applyStimulus(3'd0, 16'd20);
        applyStimulus(3'd3, 16'h0000);
        checkOutput("pre_rst_pending", o_commit_pending, 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_period",  o_period,         16'd0);
        checkOutput("mid_rst_en",      o_en,             16'd0);
        checkOutput("mid_rst_up",      o_upnotdown,      16'd1);
        checkOutput("mid_rst_pending", o_commit_pending, 16'd0);
        checkOutput("mid_rst_rd",      o_rd_data,        16'd0);
        #3;
        rst_n = 1'b1;
        i_rd_addr = 3'd0;
        tick();
        tick();
        checkOutput("post_rst_pending", o_commit_pending, 16'd0);
        checkOutput("post_rst_period",  o_period,         16'd0);
        checkOutput("post_rst_shadow",  o_rd_data,        16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
